color_msg_tx: RTL and testbench
===============================

# color_msg_tx

Serialises colour-detection events from the colour sensor block into fixed ASCII messages on a UART 8N1 line to the telemetry radio. Sits downstream of the sensor's 2-bit colour code output. Accepts one event at a time through a valid/ready handshake, holds one pending event while a message is in flight, and reports dropped events.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency.
- `BAUD`, 115200: line rate. Divisor `DIV = (CLK_HZ + BAUD/2)/BAUD`, which is 434 at the defaults.
- `DROP_W`, 8: width of the drop counter.
- `clk_50`  in  1: system clock, rising edge.
- `rst`  in  1: synchronous reset, active high.
- `evt_valid`  in  1: colour event present.
- `evt_clr`  in  2: colour code. 0 = none, 1 = red, 2 = green, 3 = blue.
- `evt_ready`  out  1: event accepted this cycle when high together with `evt_valid`.
- `tx`  out  1: UART line, idles high.
- `busy`  out  1: a message is in flight or an event is pending.
- `drop_cnt`  out  DROP_W: count of events overwritten while pending. Saturates.

## Operation
- Message format is 6 bytes, LSB first: `'C','L','R',':',<L>,0x0A`. `<L>` is `'R'` (0x52), `'G'` (0x47) or `'B'` (0x42).
- Acceptance:
  - `evt_ready` is 1 whenever `rst` = 0. The block never back-pressures.
  - The accepted event's handling depends on state:
    - Idle, no pending event: starts a message.
    - Busy, no pending event: stored in the pending register.
    - Busy, pending register full: overwrites the pending event and increments `drop_cnt`.
- Code 0 events are accepted and discarded. They never touch the pending register or `drop_cnt`.
- Main FSM states:
  - IDLE: `tx` = 1.
  - START: `tx` = 0 for DIV cycles.
  - DATA: 8 bits, each DIV cycles, LSB first.
  - STOP: `tx` = 1 for DIV cycles.
  - NEXT: byte index + 1.
- Transitions:
  - IDLE → START on a new or pending event.
  - START → DATA → STOP.
  - STOP → START if byte index < 5, else → IDLE.
- Bytes are sent back to back with no idle gap between them.
- At the end of a message, if the pending register is valid, START for the pending message begins on the cycle after the last STOP cycle. The pending register clears on the same edge.
- Simultaneous events:
  - Pending launch and a new accept in the same cycle: the new event goes into the now-empty pending register. No drop is counted.
  - Accept while IDLE: the event launches directly and does not occupy the pending register.
- `busy` = (state != IDLE) | pending_valid.

## Timing
- Reset values: `tx` = 1, `busy` = 0, `evt_ready` = 0 while `rst` = 1, `drop_cnt` = 0. FSM = IDLE, pending cleared, byte/bit/baud counters = 0.
- Reset mid-frame: `tx` returns to 1 on the first clock edge with `rst` = 1. The partial byte is abandoned and not resumed.
- Latency: `tx` falls on the cycle after acceptance while IDLE, i.e. edge N+1 for acceptance at edge N.
- Every bit lasts exactly DIV clocks. The baud counter is `$clog2(DIV)` bits wide, counts 0..DIV-1 and wraps.
- Frame length is 10·DIV cycles. A message is 60·DIV cycles, which is 26040 cycles at the defaults.
- `drop_cnt` holds at 2^DROP_W − 1 and does not wrap.

## Configuration
- Macro `COLOR_MSG_DEDUP_EN`:
  - Defined: the block keeps `last_clr`, reset to 0. An accepted event whose code equals `last_clr` is discarded: no message, no pending update, no drop count. `last_clr` updates when a message launches.
  - Undefined: every non-zero event is transmitted or queued, with no `last_clr` state.

## Structure
- Package `color_pkg` holds:
  - Colour code constants `CLR_NONE/RED/GREEN/BLUE`.
  - ASCII constants for the message bytes.
  - `MSG_LEN` = 6.
  - An FSM state enum.
- Sub-module `uart_byte_tx` handles one 8N1 frame:
  - Inputs `clk_50`, `rst`, `start`, `data[7:0]`.
  - Outputs `tx`, `done`, where `done` is a 1-cycle pulse on the last STOP cycle.
  - Parameter `DIV`.
- The top level holds the message sequencer, the pending register, dedup and the drop counter.

## Test plan
- Reset then `evt_clr`=1 pulse → `tx` low on the next edge. Decoded bytes are 0x43,0x4C,0x52,0x3A,0x52,0x0A. Each bit is 434 cycles. `busy` clears after 26040 cycles.
- Mid-frame `rst` pulse during the byte-2 DATA state → `tx`=1 next edge, `busy`=0, no further bytes. A new event afterwards produces a clean full message.
- Events 2 then 3 issued 100 cycles apart → two back-to-back messages with `<L>` = 0x47 then 0x42. There is no idle gap between them and `drop_cnt` = 0.
- Events 1, 2, 3 issued within the first message → messages 'R' then 'B', `drop_cnt` = 1. With `DROP_W`=2 and 5 overwrites, `drop_cnt` saturates at 3.
- `evt_clr`=0 pulse → `tx` stays 1, `busy` stays 0, `drop_cnt` unchanged.
- With `COLOR_MSG_DEDUP_EN` defined, events 1, 1, 3 → two messages ('R', 'B'). Without the macro, three messages ('R', 'R', 'B').

Source files
------------

// File: rtl/color_pkg.sv
// rtl/color_pkg.sv - colour codes, message ASCII constants and UART FSM states
package color_pkg;

   localparam logic [1:0] CLR_NONE  = 2'd0;
   localparam logic [1:0] CLR_RED   = 2'd1;
   localparam logic [1:0] CLR_GREEN = 2'd2;
   localparam logic [1:0] CLR_BLUE  = 2'd3;

   localparam logic [7:0] ASC_C     = 8'h43;
   localparam logic [7:0] ASC_L     = 8'h4C;
   localparam logic [7:0] ASC_R     = 8'h52;
   localparam logic [7:0] ASC_COLON = 8'h3A;
   localparam logic [7:0] ASC_G     = 8'h47;
   localparam logic [7:0] ASC_B     = 8'h42;
   localparam logic [7:0] ASC_LF    = 8'h0A;

   localparam int MSG_LEN = 6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } tx_state_t;

   // Byte idx of the message "CLR:<L>\n" for colour clr.
   function automatic logic [7:0] msg_byte(input logic [2:0] idx, input logic [1:0] clr);
      logic [7:0] v_ltr;
      case (clr)
         CLR_RED:   v_ltr = ASC_R;
         CLR_GREEN: v_ltr = ASC_G;
         default:   v_ltr = ASC_B;
      endcase
      case (idx)
         3'd0:    msg_byte = ASC_C;
         3'd1:    msg_byte = ASC_L;
         3'd2:    msg_byte = ASC_R;
         3'd3:    msg_byte = ASC_COLON;
         3'd4:    msg_byte = v_ltr;
         default: msg_byte = ASC_LF;
      endcase
   endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - one 8N1 frame; done pulses on the last STOP cycle
module uart_byte_tx
   import color_pkg::*;
#(
   parameter int DIV = 434
) (
   input  logic       clk_50,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       done
);

   localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

   tx_state_t       r_state;
   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_bit;
   logic [7:0]      r_sh;
   logic            r_tx;
   logic            w_last;
   logic            w_done;

   assign w_last = (r_cnt == LAST);
   assign w_done = (r_state == ST_STOP) && w_last;
   assign done   = w_done;
   assign tx     = r_tx;

   always_ff @(posedge clk_50) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_sh    <= '0;
         r_tx    <= 1'b1;
      end else if (start && ((r_state == ST_IDLE) || w_done)) begin
         // A start during the final STOP cycle chains frames with no idle gap.
         r_state <= ST_START;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_sh    <= data;
         r_tx    <= 1'b0;
      end else if (r_state != ST_IDLE) begin
         if (!w_last) begin
            r_cnt <= r_cnt + 1'b1;
         end else begin
            r_cnt <= '0;
            case (r_state)
               ST_START: begin
                  r_state <= ST_DATA;
                  r_tx    <= r_sh[0];
               end
               ST_DATA: begin
                  if (r_bit == 3'd7) begin
                     r_state <= ST_STOP;
                     r_tx    <= 1'b1;
                  end else begin
                     r_bit <= r_bit + 3'd1;
                     r_sh  <= r_sh >> 1;
                     r_tx  <= r_sh[1];
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_tx    <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/color_msg_tx.sv
// rtl/color_msg_tx.sv - colour events to "CLR:<L>\n" UART messages with one pending slot
// Optional macro COLOR_MSG_DEDUP_EN discards events repeating the last launched colour.
module color_msg_tx
   import color_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000,
   parameter int BAUD   = 115200,
   parameter int DROP_W = 8
) (
   input  logic              clk_50,
   input  logic              rst,
   input  logic              evt_valid,
   input  logic [1:0]        evt_clr,
   output logic              evt_ready,
   output logic              tx,
   output logic              busy,
   output logic [DROP_W-1:0] drop_cnt
);

   localparam int         DIV      = (CLK_HZ + BAUD / 2) / BAUD;
   localparam logic [2:0] LAST_IDX = 3'(MSG_LEN - 1);

   logic              r_active;
   logic              r_kick;
   logic [2:0]        r_byte_idx;
   logic [1:0]        r_cur_clr;
   logic              r_pend_valid;
   logic [1:0]        r_pend_clr;
   logic [DROP_W-1:0] r_drop;

   logic              w_done;
   logic              w_tx;
   logic              w_evt_ok;
   logic              w_msg_end;
   logic              w_launch_new;
   logic              w_launch_pend;
   logic              w_pend_free;
   logic              w_start;
   logic [2:0]        w_tx_idx;
   logic [1:0]        w_tx_clr;
   logic [7:0]        w_tx_byte;

`ifdef COLOR_MSG_DEDUP_EN
   logic [1:0]        r_last_clr;
   assign w_evt_ok = evt_valid && (evt_clr != CLR_NONE) && (evt_clr != r_last_clr);
`else
   assign w_evt_ok = evt_valid && (evt_clr != CLR_NONE);
`endif

   assign evt_ready     = ~rst;
   assign busy          = r_active | r_pend_valid;
   assign drop_cnt      = r_drop;
   assign tx            = w_tx;

   assign w_msg_end     = r_active && w_done && (r_byte_idx == LAST_IDX);
   assign w_launch_pend = r_pend_valid && (w_msg_end || !r_active);
   assign w_launch_new  = !r_active && !r_pend_valid && w_evt_ok;
   assign w_pend_free   = !r_pend_valid || w_launch_pend;
   // First byte of an idle launch goes out via r_kick; chained bytes start on done.
   assign w_start       = r_kick || (r_active && w_done && (!w_msg_end || r_pend_valid));

   always_comb begin
      w_tx_idx = r_byte_idx;
      w_tx_clr = r_cur_clr;
      if (w_msg_end) begin
         w_tx_idx = 3'd0;
         w_tx_clr = r_pend_clr;
      end else if (r_active && w_done) begin
         w_tx_idx = r_byte_idx + 3'd1;
      end
   end

   assign w_tx_byte = msg_byte(w_tx_idx, w_tx_clr);

   always_ff @(posedge clk_50) begin
      if (rst) begin
         r_active     <= 1'b0;
         r_kick       <= 1'b0;
         r_byte_idx   <= '0;
         r_cur_clr    <= CLR_NONE;
         r_pend_valid <= 1'b0;
         r_pend_clr   <= CLR_NONE;
         r_drop       <= '0;
      end else begin
         r_kick <= 1'b0;
         if (!r_active && (r_pend_valid || w_evt_ok)) begin
            r_active   <= 1'b1;
            r_kick     <= 1'b1;
            r_byte_idx <= '0;
            r_cur_clr  <= r_pend_valid ? r_pend_clr : evt_clr;
         end else if (r_active && w_done) begin
            if (!w_msg_end) begin
               r_byte_idx <= r_byte_idx + 3'd1;
            end else if (r_pend_valid) begin
               r_byte_idx <= '0;
               r_cur_clr  <= r_pend_clr;
            end else begin
               r_active <= 1'b0;
            end
         end

         if (w_evt_ok && !w_launch_new) begin
            r_pend_valid <= 1'b1;
            r_pend_clr   <= evt_clr;
            if (!w_pend_free && (r_drop != '1)) begin
               r_drop <= r_drop + 1'b1;
            end
         end else if (w_launch_pend) begin
            r_pend_valid <= 1'b0;
         end
      end
   end

`ifdef COLOR_MSG_DEDUP_EN
   always_ff @(posedge clk_50) begin
      if (rst) begin
         r_last_clr <= CLR_NONE;
      end else if (w_launch_new) begin
         r_last_clr <= evt_clr;
      end else if (w_launch_pend) begin
         r_last_clr <= r_pend_clr;
      end
   end
`endif

   uart_byte_tx #(
      .DIV (DIV)
   ) u_uart (
      .clk_50 (clk_50),
      .rst    (rst),
      .start  (w_start),
      .data   (w_tx_byte),
      .tx     (w_tx),
      .done   (w_done)
   );

endmodule

// File: tb/tb_color_msg_tx.sv
// tb/tb_color_msg_tx.sv - bench for color_msg_tx with an event-level timing model
module tb_color_msg_tx;

   localparam int CLK_HZ  = 1000;
   localparam int BAUD    = 100;
   localparam int DROP_W  = 2;
   localparam int D       = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int FRAME   = 10 * D;
   localparam int MSG_CYC = 6 * FRAME;
   localparam int MAXD    = (1 << DROP_W) - 1;

   logic              clk_50 = 1'b0;
   logic              rst = 1'b1;
   logic              evt_valid = 1'b0;
   logic [1:0]        evt_clr = 2'd0;
   logic              evt_ready;
   logic              tx;
   logic              busy;
   logic [DROP_W-1:0] drop_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   color_msg_tx #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD),
      .DROP_W (DROP_W)
   ) dut (
      .clk_50    (clk_50),
      .rst       (rst),
      .evt_valid (evt_valid),
      .evt_clr   (evt_clr),
      .evt_ready (evt_ready),
      .tx        (tx),
      .busy      (busy),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk_50 = ~clk_50;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] exp_byte(input int b, input logic [1:0] c);
      logic [7:0] ltr;
      ltr = (c == 2'd1) ? 8'h52 : (c == 2'd2) ? 8'h47 : 8'h42;
      case (b)
         0: return 8'h43;
         1: return 8'h4C;
         2: return 8'h52;
         3: return 8'h3A;
         4: return ltr;
         default: return 8'h0A;
      endcase
   endfunction

   // Model: message timeline in edge numbers; tx derived from offset within the message.
   bit         m_act = 0;
   bit         m_pv = 0;
   int         m_start = 0;
   int         m_drop = 0;
   logic [1:0] m_cur = 0;
   logic [1:0] m_pend = 0;
   logic [1:0] m_last = 0;
   bit         mo_ok, mo_was_act, mo_was_pv, mo_launch;

   always @(posedge clk_50) begin
      cyc++;
      if (rst) begin
         m_act = 0; m_pv = 0; m_drop = 0; m_last = 0;
      end else begin
         mo_ok = evt_valid && (evt_clr != 2'd0);
`ifdef COLOR_MSG_DEDUP_EN
         mo_ok = mo_ok && (evt_clr != m_last);
`endif
         mo_was_act = m_act;
         mo_was_pv  = m_pv;
         mo_launch  = 0;
         if (m_act && cyc == m_start + MSG_CYC) begin
            if (m_pv) begin
               m_start = cyc; m_cur = m_pend; m_last = m_pend; m_pv = 0; mo_launch = 1;
            end else begin
               m_act = 0;
            end
         end else if (!m_act && m_pv) begin
            m_act = 1; m_start = cyc + 1; m_cur = m_pend; m_last = m_pend; m_pv = 0; mo_launch = 1;
         end
         if (mo_ok) begin
            if (!mo_was_act && !mo_was_pv) begin
               m_act = 1; m_start = cyc + 1; m_cur = evt_clr; m_last = evt_clr;
            end else begin
               if (mo_was_pv && !mo_launch) m_drop = (m_drop < MAXD) ? m_drop + 1 : MAXD;
               m_pend = evt_clr;
               m_pv   = 1;
            end
         end
      end
   end

   logic       e_tx;
   int         e_off, e_slot;
   logic [7:0] e_b;

   always @(negedge clk_50) begin
      if (cyc > 0) begin
         e_tx = 1'b1;
         if (m_act && cyc >= m_start && cyc < m_start + MSG_CYC) begin
            e_off  = cyc - m_start;
            e_slot = (e_off % FRAME) / D;
            if (e_slot == 0) e_tx = 1'b0;
            else if (e_slot != 9) begin
               e_b  = exp_byte(e_off / FRAME, m_cur);
               e_tx = e_b[e_slot-1];
            end
         end
         chk("m_tx", tx, e_tx);
         chk("m_busy", busy, m_act || m_pv);
         chk("m_drop", drop_cnt, m_drop);
         chk("m_ready", evt_ready, !rst);
      end
   end

   task automatic wait_cyc(input int t);
      do @(negedge clk_50); while (cyc < t);
   endtask

   task automatic send(input logic [1:0] c, output int acc);
      @(posedge clk_50); #1;
      evt_valid = 1'b1; evt_clr = c;
      @(posedge clk_50); #1;
      acc = cyc;
      evt_valid = 1'b0; evt_clr = 2'd0;
   endtask

   // Decode one message from the line by mid-bit sampling; returns at its stop slot.
   task automatic rx_msg(output logic [47:0] m, output int tf, output bit ok, input int bound);
      int n = 0;
      m = '0; tf = 0; ok = 1;
      while (tx !== 1'b0 && n < bound) begin @(negedge clk_50); n++; end
      if (tx !== 1'b0) begin ok = 0; return; end
      tf = cyc;
      for (int f = 0; f < 6; f++)
         for (int j = 0; j < 8; j++) begin
            wait_cyc(tf + f * FRAME + (j + 1) * D + D / 2);
            m[f*8+j] = tx;
         end
      wait_cyc(tf + 5 * FRAME + 9 * D + D / 2);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0 && n < 2000) begin @(negedge clk_50); n++; end
      chk("idle_timeout", n < 2000, 1);
   endtask

   task automatic pulse_rst();
      @(posedge clk_50); #1 rst = 1'b1;
      @(posedge clk_50); #1 rst = 1'b0;
   endtask

   initial begin
      int a, b, t1, t2;
      bit ok1, ok2;
      logic [47:0] m1, m2;
      logic [1:0] evs [3];
      bit exp_ok;

      repeat (3) @(posedge clk_50);
      #1;
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ready", evt_ready, 0);
      chk("rst_drop", drop_cnt, 0);
      rst = 1'b0;
      repeat (4) @(posedge clk_50);

      // Single red message: latency, content, length.
      send(2'd1, a);
      chk("t1_tx_at_accept", tx, 1);
      chk("t1_busy_at_accept", busy, 1);
      wait_cyc(a + 1);
      chk("t1_tx_fall", tx, 0);
      rx_msg(m1, t1, ok1, 100);
      chk("t1_rx_ok", ok1, 1);
      chk("t1_fall_edge", t1, a + 1);
      chk("t1_msg", m1, 48'h0A523A524C43);
      wait_cyc(a + MSG_CYC);
      chk("t1_busy_last", busy, 1);
      wait_cyc(a + MSG_CYC + 1);
      chk("t1_busy_clear", busy, 0);

      // Reset during byte 2 data, then a clean blue message.
      repeat (10) @(posedge clk_50);
      send(2'd1, a);
      wait_cyc(a + 1 + 2 * FRAME + D + 5);
      @(posedge clk_50); #1 rst = 1'b1;
      @(posedge clk_50); #1;
      chk("t2_rst_tx", tx, 1);
      chk("t2_rst_busy", busy, 0);
      rst = 1'b0;
      wait_cyc(cyc + 300);
      chk("t2_quiet_tx", tx, 1);
      chk("t2_quiet_busy", busy, 0);
      send(2'd3, a);
      rx_msg(m1, t1, ok1, 100);
      chk("t2_rx_ok", ok1, 1);
      chk("t2_msg", m1, 48'h0A423A524C43);
      wait_idle();

      // Green then blue 100 cycles apart: back to back, no drop.
      fork
         begin send(2'd2, a); repeat (99) @(posedge clk_50); send(2'd3, b); end
         begin rx_msg(m1, t1, ok1, 50); rx_msg(m2, t2, ok2, 50); end
      join
      chk("t3_ok", {ok1, ok2}, 2'b11);
      chk("t3_l1", m1[39:32], 8'h47);
      chk("t3_l2", m2[39:32], 8'h42);
      chk("t3_gap", t2, t1 + MSG_CYC);
      chk("t3_drop", drop_cnt, 0);
      wait_idle();

      // 1,2,3 within one message: green overwritten.
      fork
         begin
            send(2'd1, a); repeat (50) @(posedge clk_50);
            send(2'd2, a); repeat (50) @(posedge clk_50);
            send(2'd3, a);
         end
         begin rx_msg(m1, t1, ok1, 50); rx_msg(m2, t2, ok2, 50); end
      join
      chk("t4_ok", {ok1, ok2}, 2'b11);
      chk("t4_l1", m1[39:32], 8'h52);
      chk("t4_l2", m2[39:32], 8'h42);
      chk("t4_drop", drop_cnt, 1);
      wait_idle();

      // Saturation: one pending plus five overwrites with a 2-bit counter.
      pulse_rst();
      chk("t5_drop_rst", drop_cnt, 0);
      send(2'd1, a);
      evs[0] = 2'd2; evs[1] = 2'd3; evs[2] = 2'd1;
      for (int i = 0; i < 6; i++) begin
         repeat (20) @(posedge clk_50);
         send(evs[i % 3], a);
      end
      @(negedge clk_50);
      chk("t5_drop_sat", drop_cnt, 3);
      wait_idle();

      // Colour 0 is swallowed.
      send(2'd0, a);
      repeat (20) @(negedge clk_50);
      chk("t6_tx", tx, 1);
      chk("t6_busy", busy, 0);
      chk("t6_drop", drop_cnt, 3);

      // Spaced 1,1,3: repeats suppressed only with dedup.
      pulse_rst();
      evs[0] = 2'd1; evs[1] = 2'd1; evs[2] = 2'd3;
      for (int i = 0; i < 3; i++) begin
`ifdef COLOR_MSG_DEDUP_EN
         exp_ok = (i != 1);
`else
         exp_ok = 1;
`endif
         fork
            send(evs[i], a);
            rx_msg(m1, t1, ok1, 50);
         join
         chk("t7_msg_present", ok1, exp_ok);
         if (ok1) chk("t7_letter", m1[39:32], (evs[i] == 2'd1) ? 8'h52 : 8'h42);
         wait_idle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
